servant_trace_buf: RTL
======================

# servant_trace_buf

Parametrised PC trace capture for the servant SoC: it samples fetch addresses from the SERV instruction bus and stores them in an on-chip FIFO. A runtime mode filters the capture to all fetches, jump targets only, or the first fetch after an interrupt. A testbench or debug host drains the FIFO over a valid/ready port. It sits beside the CPU in simulation and debug builds and replaces ad-hoc probing of `pc_adr`/`pc_vld`/`isjump`.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; must be a power of two, ≥ 2.
- `AW`, 32: captured address width.
- `OVF_W`, 16: overflow counter width.

Ports:
- `wb_clk`  in  1  system clock.
- `wb_rst`  in  1  reset, synchronous, active-high.
- `i_mode`  in  2  capture mode: 0 off, 1 all fetches, 2 jumps, 3 IRQ entry.
- `i_pc_adr`  in  AW  fetch address (`wb_mem_adr`).
- `i_pc_vld`  in  1  fetch acknowledge (`wb_mem_ack`).
- `i_isjump`  in  1  CPU jump flag.
- `i_irq`  in  1  OR of the timer and external IRQ lines.
- `o_rd_data`  out  AW  head-entry address.
- `o_rd_ts`  out  32  head-entry timestamp.
- `o_rd_vld`  out  1  head entry valid.
- `i_rd_rdy`  in  1  consumer ready.
- `o_level`  out  $clog2(DEPTH)+1  occupancy.
- `o_ovf_cnt`  out  OVF_W  dropped-capture count, saturating.
- `i_clr_ovf`  in  1  clears `o_ovf_cnt`.

## Operation
Capture qualifier `cap`, evaluated each cycle:
- Mode 0: `cap` is never asserted.
- Mode 1: `cap = i_pc_vld`.
- Mode 2: `cap = i_pc_vld & i_isjump`.
- Mode 3: a rising edge of `i_irq` sets `armed`. Then `cap = i_pc_vld & armed`, and `armed` clears in the same cycle.
  - `armed` clears whenever `i_mode` ≠ 3.
  - An edge coinciding with an armed capture re-arms for the next fetch.

Push and pop:
- Push happens when `cap` is asserted and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- When `cap` is asserted, the FIFO is full and no pop occurs, the entry is dropped. `o_ovf_cnt` increments and saturates at all-ones.
- Pop happens when `o_rd_vld & i_rd_rdy`.
- A simultaneous push and pop leaves `o_level` unchanged.
- The pointers are $clog2(DEPTH) bits and wrap naturally.

Overflow counter:
- `i_clr_ovf` takes priority over an increment in the same cycle, so the result is 0.

Mode changes:
- A mode change takes effect on the next `cap` evaluation.
- FIFO contents are kept across mode changes.

## Timing
Reset (`wb_rst` high at a `wb_clk` edge):
- FIFO is empty and `armed` is 0.
- `o_rd_vld` is 0, `o_level` is 0, `o_ovf_cnt` is 0.
- `o_rd_data` and `o_rd_ts` are 0.
- A reset in the middle of traffic discards all entries.

Latency:
- An entry captured at edge N is visible with `o_rd_vld` high after edge N.
- `o_rd_data`/`o_rd_ts` change only on a pop or on a push into an empty FIFO, and are stable while `o_rd_vld & !i_rd_rdy`.
- `o_level` is registered and reflects the push/pop of the previous edge.
- The `i_irq` edge is detected against a registered copy, so an edge at N arms `armed` from N+1.

## Configuration
`SERVANT_TRACE_TIMESTAMP_EN`:
- Defined: a 32-bit free-running cycle counter (0 at reset, wraps) is stored with each entry and presented on `o_rd_ts`.
- Undefined: the counter and the timestamp storage are omitted, and `o_rd_ts` is tied to 0. The port list is identical in both builds.

## Structure
- Package `servant_trace_pkg`:
  - mode constants `TRACE_OFF`, `TRACE_ALL`, `TRACE_JUMP`, `TRACE_IRQ`.
  - `TS_W = 32`.
- Sub-module `servant_trace_fifo`: a generic synchronous valid/ready FIFO with level output.
- The top level holds the qualifier, the arm flag, the overflow counter and the timestamp.

## Test plan
- Mode 1, 5 fetches at 0x0, 0x4, 0x8, 0xC, 0x10 with `i_rd_rdy` = 0 -> `o_level` = 5; draining returns the addresses in order.
- Mode 2, fetch 0x40 with `i_isjump` = 0, then 0x80 with `i_isjump` = 1 -> exactly one entry, 0x80.
- Mode 3, `i_irq` rising edge, then fetches 0x10 and 0x14 -> one entry, 0x10; a second IRQ without an edge produces no entry.
- DEPTH = 16, mode 1, 20 fetches with no reads -> `o_level` = 16, `o_ovf_cnt` = 4. A full FIFO with simultaneous push+pop -> level stays 16 and the counter is unchanged. `i_clr_ovf` -> counter 0.
- Backpressure: toggle `i_rd_rdy` randomly over 200 captures -> no loss and no duplication, data stable while stalled. With the macro defined, timestamps strictly increase.
- Assert `wb_rst` with 7 entries queued -> next cycle `o_rd_vld` = 0 and `o_level` = 0.

Source files
------------

// File: rtl/servant_trace_pkg.sv
// servant_trace_pkg: capture-mode encoding and timestamp width shared by the trace buffer.
package servant_trace_pkg;
    typedef enum logic [1:0] {
        TRACE_OFF  = 2'd0,
        TRACE_ALL  = 2'd1,
        TRACE_JUMP = 2'd2,
        TRACE_IRQ  = 2'd3
    } trace_mode_e;
    localparam int TS_W = 32;
endpackage

// File: rtl/servant_trace_fifo.sv
// servant_trace_fifo: synchronous valid/ready FIFO with occupancy output; head reads 0 while empty.
module servant_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_vld,
    input  logic [W-1:0]             i_wr_data,
    output logic                     o_wr_rdy,
    output logic [W-1:0]             o_rd_data,
    output logic                     o_rd_vld,
    input  logic                     i_rd_rdy,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_level;
    logic          w_push;
    logic          w_pop;
    assign o_rd_vld  = r_level != '0;
    assign w_pop     = o_rd_vld & i_rd_rdy;
    assign o_wr_rdy  = (r_level != (PW+1)'(DEPTH)) | w_pop;
    assign w_push    = i_wr_vld & o_wr_rdy;
    assign o_rd_data = o_rd_vld ? r_mem[r_rd_ptr] : '0;
    assign o_level   = r_level;
    // storage write; contents need no reset because the head is masked while empty
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end
    // pointers wrap naturally; level tracks push minus pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_wr_ptr <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
            r_rd_ptr <= w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
            r_level  <= (w_push & !w_pop) ? r_level + 1'b1 : (!w_push & w_pop) ? r_level - 1'b1 : r_level;
        end
    end
endmodule

// File: rtl/servant_trace_buf.sv
// servant_trace_buf: PC trace capture FIFO; SERVANT_TRACE_TIMESTAMP_EN adds a per-entry cycle timestamp.
module servant_trace_buf
    import servant_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 32,
    parameter int OVF_W = 16
) (
    input  logic                     wb_clk,
    input  logic                     wb_rst,
    input  logic [1:0]               i_mode,
    input  logic [AW-1:0]            i_pc_adr,
    input  logic                     i_pc_vld,
    input  logic                     i_isjump,
    input  logic                     i_irq,
    output logic [AW-1:0]            o_rd_data,
    output logic [31:0]              o_rd_ts,
    output logic                     o_rd_vld,
    input  logic                     i_rd_rdy,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic [OVF_W-1:0]         o_ovf_cnt,
    input  logic                     i_clr_ovf
);
`ifdef SERVANT_TRACE_TIMESTAMP_EN
    localparam int FW = AW + TS_W;
`else
    localparam int FW = AW;
`endif
    logic          r_irq_q;
    logic          r_armed;
    logic          w_irq_edge;
    logic          w_cap;
    logic          w_wr_rdy;
    logic          w_drop;
    logic [FW-1:0] w_wr_data;
    logic [FW-1:0] w_rd_data;
    assign w_irq_edge = i_irq & !r_irq_q;
    assign w_drop     = w_cap & !w_wr_rdy;
    // capture qualifier selected by the runtime mode
    always_comb begin
        w_cap = (i_mode == TRACE_ALL)  ? i_pc_vld :
                (i_mode == TRACE_JUMP) ? i_pc_vld & i_isjump :
                (i_mode == TRACE_IRQ)  ? i_pc_vld & r_armed : 1'b0;
    end
    // irq edge detection and arm flag; a new edge wins over the capture that consumes the arm
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_irq_q <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_irq_q <= i_irq;
            r_armed <= (i_mode != TRACE_IRQ) ? 1'b0 : w_irq_edge ? 1'b1 : w_cap ? 1'b0 : r_armed;
        end
    end
    // saturating drop counter; clear beats a same-cycle increment
    always_ff @(posedge wb_clk) begin
        if (wb_rst || i_clr_ovf) o_ovf_cnt <= '0;
        else if (w_drop && !(&o_ovf_cnt)) o_ovf_cnt <= o_ovf_cnt + 1'b1;
    end
`ifdef SERVANT_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;
    // free-running cycle counter stamped onto every captured entry
    always_ff @(posedge wb_clk) begin
        if (wb_rst) r_ts <= '0;
        else r_ts <= r_ts + 1'b1;
    end
    assign w_wr_data = {r_ts, i_pc_adr};
    assign o_rd_data = w_rd_data[AW-1:0];
    assign o_rd_ts   = w_rd_data[FW-1:AW];
`else
    assign w_wr_data = i_pc_adr;
    assign o_rd_data = w_rd_data;
    assign o_rd_ts   = '0;
`endif
    servant_trace_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
        .clk       (wb_clk),
        .rst       (wb_rst),
        .i_wr_vld  (w_cap),
        .i_wr_data (w_wr_data),
        .o_wr_rdy  (w_wr_rdy),
        .o_rd_data (w_rd_data),
        .o_rd_vld  (o_rd_vld),
        .i_rd_rdy  (i_rd_rdy),
        .o_level   (o_level)
    );
endmodule
